// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
// State encoding keeps FULL as the only code with bit 1 set.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

endpackage

// File: rtl/pipe_data_reg.sv
// Width-parametrised enable register.
// Synchronous active-high reset loads RESET_VALUE.
module pipe_data_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VALUE;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with valid/ready handshake and one-entry skid.
// in_ready is a pure function of the registered state.
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  logic                  main_en;
  logic                  skid_en;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_q;

  logic in_fire;
  logic out_fire;

  assign in_ready  = ~state_q[1];
  assign out_valid = (state_q != ST_EMPTY);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Draining FULL refills main from the skid entry.
  assign main_d = (state_q == ST_FULL) ? skid_q : in_data;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_BUSY;
            main_en = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_BUSY;
            main_en = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_data_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .en_i (main_en),
    .d_i  (main_d),
    .q_o  (out_data)
  );

  pipe_data_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .en_i (skid_en),
    .d_i  (in_data),
    .q_o  (skid_q)
  );

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
Parametrised pipeline-stage register: the successor of the plain enable register, with a valid/ready handshake on both sides and a one-entry skid buffer.
- Sustains 1 transfer/cycle with fully registered in_ready, so there is no combinational ready path between stages.
- Adds synchronous flush for pipeline kill (branch mispredict, exception).
- Placed between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and on bus/peripheral data paths.

Parameters:
DATA_WIDTH, 32, width of the payload carried through the stage
RESET_VALUE, 0, value driven on out_data after reset (DATA_WIDTH bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high; one clock, reset is synchronous and active-high
flush  input  1  synchronous kill of all held entries, active-high
in_valid  input  1  upstream has data on in_data
in_ready  output  1  stage can accept; registered (function of state only)
in_data  input  DATA_WIDTH  upstream payload
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream accepts this cycle
out_data  output  DATA_WIDTH  payload, driven directly from main register

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) plus skid register.
- States: EMPTY (0 entries), BUSY (main valid), FULL (main + skid valid).
- Outputs by state: out_valid = (state != EMPTY); in_ready = (state != FULL).
- Reset (rst=1 at clk edge): state=EMPTY, main=RESET_VALUE, skid=RESET_VALUE. After reset: out_valid=0, in_ready=1, out_data=RESET_VALUE.
- Reset priority: rst > flush > normal operation.
- EMPTY:
  - in_fire -> BUSY, main<=in_data.
  - otherwise stay.
- BUSY:
  - in_fire & out_fire -> BUSY, main<=in_data.
  - in_fire & !out_fire -> FULL, skid<=in_data; main unchanged.
  - !in_fire & out_fire -> EMPTY.
  - neither -> stay.
- FULL (in_ready=0, so in_valid is ignored):
  - out_fire -> BUSY, main<=skid.
  - otherwise stay.
- Latency: in_fire at edge N makes out_valid=1 and out_data=payload after edge N.
- Throughput: 1 transfer/cycle when out_ready is held high.
- Ordering: strict FIFO, no loss, no duplication.
- Stability: while out_valid & !out_ready, out_data and out_valid must not change.
- Flush (rst=0, flush=1): state<=EMPTY next cycle.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts downstream; it is the consumer's job to qualify it.
  - Data registers are not cleared; out_data holds its last value, meaningless while out_valid=0.
- Held values: out_data while out_valid=0 holds the last value (or RESET_VALUE after reset); no X.
- Reset mid-transfer: all entries dropped; no partial update of main/skid in the reset cycle.
- Width: payload is copied verbatim; no arithmetic. RESET_VALUE is truncated/zero-extended to DATA_WIDTH.

Decomposition:
- Shared package pipe_pkg: state encoding as 2-bit constants ST_EMPTY=2'b00, ST_BUSY=2'b01, ST_FULL=2'b10. ST_FULL is the only encoding with bit1 set, so in_ready = ~state[1].
- Sub-module pipe_data_reg: width-parametrised enable register with synchronous active-high reset to RESET_VALUE. Instantiated twice, for main and skid.
- Top level holds the FSM and the mux main_d = (state==FULL) ? skid : in_data.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> out_valid=0, in_ready=1, out_data=0. With RESET_VALUE=32'hDEADBEEF, out_data=32'hDEADBEEF.
- Streaming: out_ready=1, in_valid=1 with 1,2,3,...,100 on consecutive cycles -> out_data 1..100 one cycle later, one per cycle; in_ready never drops.
- Backpressure/skid: push 0xA then 0xB while out_ready=0 -> after 2 edges state FULL, in_ready=0, out_data=0xA. A third word 0xC held on in_valid is not taken. Raise out_ready -> outputs 0xA, 0xB, 0xC in order; in_ready returns 1 one cycle after the first out_fire.
- Flush: in FULL with 0x11/0x22, pulse flush with in_valid=1, in_data=0x33 -> next cycle out_valid=0, in_ready=1; 0x33 never appears at output.
- Reset mid-operation: FULL with 0x55/0x66, assert rst one cycle with in_valid=1 -> out_valid=0, out_data=RESET_VALUE, in_ready=1; the next push of 0x77 is output after 1 cycle.
- Random: random in_valid/out_ready over 10k cycles -> scoreboard shows no loss, duplication or reordering; out_data stable whenever out_valid & !out_ready.
